// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache control slice (cache_cu and
// cache_line_xfer): transfer-engine state encoding, default line geometry and
// helpers that split a byte address into its line and word-offset fields.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    DONE      = 2'd3
  } xfer_state_t;

  localparam int CACHE_ADDR_W     = 32;
  localparam int CACHE_DATA_W     = 32;
  localparam int CACHE_LINE_WORDS = 4;
  localparam int CACHE_OFF_W      = $clog2(CACHE_LINE_WORDS);
  localparam int CACHE_LINE_W     = CACHE_ADDR_W - CACHE_OFF_W - 2;

  // Line number: everything above the word offset and byte bits.
  function automatic logic [CACHE_LINE_W-1:0] line_of(input logic [CACHE_ADDR_W-1:0] addr);
    return addr[CACHE_ADDR_W-1:CACHE_OFF_W+2];
  endfunction

  // Word offset within the line; byte bits [1:0] are dropped.
  function automatic logic [CACHE_OFF_W-1:0] off_of(input logic [CACHE_ADDR_W-1:0] addr);
    return addr[CACHE_OFF_W+1:2];
  endfunction

endpackage

// File: rtl/cache_line_xfer.sv
// cache_line_xfer: line-transfer engine between the data cache and memory.
// On a miss (start) it writes back the dirty victim line, then refills the
// missing line critical-word-first over a single-word req/ack port, and
// pulses done/tag_update for one cycle so cache_cu can retry the access.
// Ports:
//   clk, rst_b                  clock, async active-low reset
//   start, victim_dirty,
//   victim_addr, miss_addr      miss request, captured in IDLE
//   cache_rd_word/cache_rdata   victim word read (combinational array read)
//   cache_wr_en/word/wdata      refill word write into the line
//   tag_update                  pulse: new tag, valid=1, dirty=0
//   mem_req/we/addr/wdata       memory request side
//   mem_rdata/mem_ack           memory response side
//   busy, done                  status
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int DATA_W     = CACHE_DATA_W,
  parameter int LINE_WORDS = CACHE_LINE_WORDS,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int LINE_W    = ADDR_W - OFF_W - 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic [OFF_W-1:0]  cache_rd_word,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_wr_en,
  output logic [OFF_W-1:0]  cache_wr_word,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              tag_update,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  xfer_state_t         state_q;
  logic [OFF_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   victim_line_q;
  logic [LINE_W-1:0]   miss_line_q;
  logic [OFF_W-1:0]    miss_off_q;
  logic [OFF_W-1:0]    refill_off_s;
  logic                unused_addr_bits_s;

  // Byte/offset bits of the victim address and byte bits of the miss address
  // carry no information for line transfers.
  assign unused_addr_bits_s = ^{victim_addr[OFF_W+1:0], miss_addr[1:0]};

  // Critical word first: start at the missing word, wrap inside the line.
  // OFF_W-bit addition wraps modulo LINE_WORDS for free.
  assign refill_off_s = miss_off_q + cnt_q;

  // Transfer sequencer: state, word counter and captured miss context.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      victim_line_q <= '0;
      miss_line_q   <= '0;
      miss_off_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            victim_line_q <= victim_addr[ADDR_W-1:OFF_W+2];
            miss_line_q   <= miss_addr[ADDR_W-1:OFF_W+2];
            miss_off_q    <= miss_addr[OFF_W+1:2];
            cnt_q         <= '0;
            state_q       <= victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (cnt_q == LAST_WORD) begin
              cnt_q   <= '0;
              state_q <= REFILL;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            // Counter wraps back to 0 on the last word.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state only; start never reaches mem_*.
  // Data pass-throughs are gated so every output is 0 outside its phase.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    tag_update    = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cache_rd_word = '0;
    cache_wr_en   = 1'b0;
    cache_wr_word = '0;
    cache_wdata   = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      WRITEBACK: begin
        busy          = 1'b1;
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = {victim_line_q, cnt_q, 2'b00};
        cache_rd_word = cnt_q;
        mem_wdata     = cache_rdata;
      end
      REFILL: begin
        busy          = 1'b1;
        mem_req       = 1'b1;
        mem_addr      = {miss_line_q, refill_off_s, 2'b00};
        cache_wr_en   = mem_ack;
        cache_wr_word = refill_off_s;
        cache_wdata   = mem_rdata;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        tag_update = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_line_xfer.sv
// Self-checking bench for cache_line_xfer. A reference model builds, per miss,
// the ordered list of memory transfers the line engine must perform and
// checks every cycle's request, cache-side strobes and the done latency.
module tb_cache_line_xfer;
  import cache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic          victim_dirty;
  logic [AW-1:0] victim_addr;
  logic [AW-1:0] miss_addr;
  logic [OW-1:0] cache_rd_word;
  logic [DW-1:0] cache_rdata;
  logic          cache_wr_en;
  logic [OW-1:0] cache_wr_word;
  logic [DW-1:0] cache_wdata;
  logic          tag_update;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] vic_words [LW];
  logic [DW-1:0] salt;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          word;
  } op_t;
  op_t ops[$];

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  assign cache_rdata = vic_words[cache_rd_word];
  assign mem_rdata   = mem_val(mem_addr);

  cache_line_xfer #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .victim_dirty(victim_dirty),
    .victim_addr(victim_addr), .miss_addr(miss_addr),
    .cache_rd_word(cache_rd_word), .cache_rdata(cache_rdata),
    .cache_wr_en(cache_wr_en), .cache_wr_word(cache_wr_word),
    .cache_wdata(cache_wdata), .tag_update(tag_update),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_req"},     32'(mem_req), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
    chk({tag, "_tag"},     32'(tag_update), 32'd0);
    chk({tag, "_wr_en"},   32'(cache_wr_en), 32'd0);
  endtask

  // Expected transfer list: victim words 0..N-1 in order, then the missing
  // line starting at the missed word and wrapping.
  task automatic build_ops(input bit dirty, input logic [31:0] va, input logic [31:0] ma);
    logic [31:0] vbase;
    logic [31:0] mbase;
    logic [31:0] a;
    int first;
    int off;
    vbase = va & ~32'(LW * 4 - 1);
    mbase = ma & ~32'(LW * 4 - 1);
    first = int'((ma / 4) % LW);
    ops.delete();
    if (dirty) begin
      for (int i = 0; i < LW; i++) begin
        ops.push_back('{1'b1, vbase + 32'(4 * i), vic_words[i], i});
      end
    end
    for (int i = 0; i < LW; i++) begin
      off = (first + i) % LW;
      a   = mbase + 32'(4 * off);
      ops.push_back('{1'b0, a, mem_val(a), off});
    end
  endtask

  task automatic run_xfer(input bit dirty, input logic [31:0] va, input logic [31:0] ma,
                          input int waits, input bit hold_start, input int abort_after);
    int  idx = 0;
    int  w = 0;
    int  c = 1;
    int  exp_done;
    bit  seen_done = 1'b0;
    for (int i = 0; i < LW; i++) vic_words[i] = $urandom;
    salt = $urandom;
    build_ops(dirty, va, ma);
    exp_done = ops.size() * (waits + 1) + 1;

    @(negedge clk);
    start = 1'b1; victim_dirty = dirty; victim_addr = va; miss_addr = ma; mem_ack = 1'b0;
    @(negedge clk);
    if (!hold_start) begin
      start = 1'b0; victim_dirty = 1'($urandom); victim_addr = $urandom; miss_addr = $urandom;
    end

    while (!seen_done && c < 200) begin
      if (abort_after >= 0 && idx == abort_after) begin
        rst_b = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge clk);
        chk_idle("abort_hold");
        rst_b = 1'b1;
        start = 1'b0;
        return;
      end
      if (idx < ops.size()) begin
        chk("busy",     32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("mem_req",  32'(mem_req), 32'd1);
        chk("mem_we",   32'(mem_we), 32'(ops[idx].we));
        chk("mem_addr", mem_addr, ops[idx].addr);
        if (ops[idx].we) begin
          chk("rd_word",   32'(cache_rd_word), 32'(ops[idx].word));
          chk("mem_wdata", mem_wdata, ops[idx].wdata);
        end
        mem_ack = (w == waits);
        #1;
        if (ops[idx].we) begin
          chk("wr_en_wb", 32'(cache_wr_en), 32'd0);
        end else begin
          chk("wr_en", 32'(cache_wr_en), 32'(mem_ack));
          if (mem_ack) begin
            chk("wr_word", 32'(cache_wr_word), 32'(ops[idx].word));
            chk("wdata",   cache_wdata, ops[idx].wdata);
          end
        end
        if (mem_ack) begin
          idx++;
          w = 0;
        end else begin
          w++;
        end
      end else begin
        chk("done_cycle", 32'(c), 32'(exp_done));
        chk("done",       32'(done), 32'd1);
        chk("tag_update", 32'(tag_update), 32'd1);
        chk("req_in_done", 32'(mem_req), 32'd0);
        mem_ack   = 1'b1;
        seen_done = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    if (!seen_done) chk("timeout", 32'd0, 32'd1);
    start = 1'b0;
    chk_idle("post");
    @(negedge clk);
    chk_idle("post2");
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; victim_dirty = 1'b0; victim_addr = '0; miss_addr = '0;
    mem_ack = 1'b0; salt = 32'h1234_5678;
    for (int i = 0; i < LW; i++) vic_words[i] = $urandom;
    #12;
    chk_idle("reset");
    chk("reset_we",    32'(mem_we), 32'd0);
    chk("reset_addr",  mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_cwd",   cache_wdata, 32'd0);
    chk("reset_rdw",   32'(cache_rd_word), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Ack asserted while idle must be ignored.
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("idle_ack");
    end
    mem_ack = 1'b0;

    run_xfer(1'b0, $urandom, 32'h0000_0048, 0, 1'b0, -1);
    run_xfer(1'b1, 32'h0000_1040, 32'h0000_2040, 0, 1'b0, -1);
    run_xfer(1'b0, $urandom, $urandom, 3, 1'b0, -1);
    run_xfer(1'b0, $urandom, 32'h0000_0048, 0, 1'b0, 2);
    run_xfer(1'b0, $urandom, $urandom, 0, 1'b0, -1);
    run_xfer(1'b1, $urandom, $urandom, 0, 1'b1, -1);
    run_xfer(1'b0, $urandom, 32'h0000_004C, 0, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 2)), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
